keypad_scanner: RTL
===================

Name: keypad_scanner

Overview:
- Drives a 4-row x 3-column phone-style key matrix and samples its columns.
- Debounces the result and presents a one-hot, active-high `keys[9:0]` vector to the microwave keypad encoder. Encoder rule: keys == 0 means no key pressed.
- Sits between the front-panel matrix pins and the encoder's `code` input, on the same `clk`.

Parameters:
- SCAN_DIV, 100, clock cycles each row is driven (row dwell); legal range 2..1023.
- DEBOUNCE_SCANS, 4, consecutive identical full frames required before a code is committed; legal range 1..15.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- cols_n  input  3  column sense lines, active-low (pulled up externally); bit 0 is the leftmost column.
- rows_n  output  4  row drive lines, active-low, exactly one low at a time; bit 0 is the top row.
- keys  output  10  committed key, one-hot active-high; bit n = digit n; all-zero = none.
- key_strobe  output  1  one-cycle pulse when keys changes from a non-zero value or zero to a new non-zero value.

Behaviour:
- Reset values:
  - rows_n = 4'b1110; keys = 0; key_strobe = 0.
  - Dwell counter = 0; row index = 0.
  - Candidate code = KEY_NONE; stable count = 0.
- Key map (row, col -> code):
  - r0: 1, 2, 3
  - r1: 4, 5, 6
  - r2: 7, 8, 9
  - r3: STAR(10), 0, HASH(11)
- Scan FSM, states DRIVE then SAMPLE, per row:
  - DRIVE: rows_n has the active row low; the dwell counter runs 0..SCAN_DIV-1.
  - SAMPLE: occurs on the cycle the counter equals SCAN_DIV-1. cols_n is captured, then the row index advances modulo 4 and rows_n updates on the next edge.
  - One frame = 4*SCAN_DIV cycles.
- Frame code accumulation:
  - Zero active columns in all rows -> KEY_NONE (14).
  - Exactly one active column in the whole frame -> that key's code.
  - More than one -> KEY_MULTI (15).
- End of frame (SAMPLE of row 3), debounce:
  - If frame code == candidate: stable count increments, saturating at DEBOUNCE_SCANS.
  - Otherwise: candidate = frame code and stable count = 1.
- Commit, registered one cycle after the row-3 SAMPLE edge, when stable count reaches DEBOUNCE_SCANS:
  - Candidate 0..9 -> keys = 1 << code.
  - KEY_NONE -> keys = 0.
  - STAR, HASH, KEY_MULTI -> keys unchanged (never committed).
- key_strobe:
  - Asserted for exactly one cycle, on the commit cycle, when keys takes a non-zero value different from its previous value.
  - Holding a key does not re-strobe.
  - Release gives no strobe.
- Press latency: DEBOUNCE_SCANS full frames, measured from the first frame in which the key is seen across the whole frame, plus 1 cycle.
- Bounce: any frame differing from the candidate restarts the count, so a glitch mid-debounce delays the commit by a full DEBOUNCE_SCANS frames.
- Key change without release: the new digit commits after its own debounce; keys switches directly between one-hot values; key_strobe pulses.
- Reset mid-frame: all state returns to reset values on the next edge; a partial frame is discarded.
- Widths:
  - Dwell counter is $clog2(SCAN_DIV) bits.
  - Stable count is 4 bits, saturating.
  - Codes are 4 bits.

Optional Feature:
- Macro: KEYPAD_STAR_HASH_EN.
- Defined: adds output ports `start_key` (1) and `stop_key` (1).
  - STAR committed -> start_key held high while committed.
  - HASH committed -> stop_key held high while committed.
  - Both are active-high levels and return low when KEY_NONE commits.
  - keys is still unchanged for STAR and HASH.
  - key_strobe does not pulse for STAR or HASH.
- Undefined: ports are absent; STAR and HASH are ignored exactly as specified above.

Decomposition:
- Package keypad_pkg:
  - Constants NUM_ROWS=4, NUM_COLS=3.
  - Codes KEY_NONE=14, KEY_MULTI=15, KEY_STAR=10, KEY_HASH=11.
  - A constant (row, col) -> code map function.
- Sub-module keypad_debounce: takes frame code plus frame-done; produces committed code, commit pulse, and stable count logic. The scanner keeps the row FSM and the frame accumulator.

Test Plan (SCAN_DIV=4, DEBOUNCE_SCANS=2; frame = 16 cycles):
- Reset, no keys (cols_n=3'b111): rows_n cycles 1110 -> 1101 -> 1011 -> 0111 every 4 cycles; keys=0; key_strobe never high.
- Hold digit 5 (cols_n[1] low while rows_n[1] low) -> keys=10'b0000100000 one cycle after the second full frame's row-3 sample (cycle 33); key_strobe high for 1 cycle; holding 10 more frames gives no further strobe.
- Release 5 -> keys=0 after 2 full empty frames; no strobe.
- Press 7 and 9 together -> KEY_MULTI; keys holds its prior value (0); no strobe.
- Digit 3 bouncing (absent in frame 2 of 3, present in frames 1, 3, 4) -> commit only at the end of frame 4; keys=10'b0000001000.
- Assert reset for 1 cycle mid-frame while 0 is held -> keys=0 and rows_n=1110 next cycle; 0 re-commits after 2 fresh full frames.
- With KEYPAD_STAR_HASH_EN defined: hold STAR -> start_key=1 after 2 frames, keys=0, no strobe.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared constants, key codes and the (row, col) -> code map for the keypad scanner.
package keypad_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 3;

  typedef logic [3:0] code_t;

  localparam code_t KEY_STAR  = 4'd10;
  localparam code_t KEY_HASH  = 4'd11;
  localparam code_t KEY_NONE  = 4'd14;
  localparam code_t KEY_MULTI = 4'd15;

  typedef enum logic {
    ST_DRIVE,
    ST_SAMPLE
  } scan_state_e;

  // Phone layout: rows 0..2 carry digits 1..9, bottom row is STAR, 0, HASH.
  function automatic code_t key_code(input logic [1:0] row, input logic [1:0] col);
    code_t c;
    if (row == 2'(NUM_ROWS - 1)) begin
      case (col)
        2'd0:    c = KEY_STAR;
        2'd1:    c = 4'd0;
        default: c = KEY_HASH;
      endcase
    end else begin
      c = code_t'({2'b00, row} * 4'd3 + {2'b00, col} + 4'd1);
    end
    return c;
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Frame-level debouncer: a code must repeat for DEBOUNCE_SCANS frames before commit_o fires
// (one cycle after the frame-done strobe) with the candidate code on code_o.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  frame_done_i,
  input  code_t frame_code_i,
  output logic  commit_o,
  output code_t code_o
);

  localparam logic [3:0] STABLE_MAX = 4'(DEBOUNCE_SCANS);

  code_t      cand_q, cand_d;
  logic [3:0] stable_q, stable_d;
  logic       done_q;

  always_comb begin
    cand_d   = cand_q;
    stable_d = stable_q;
    if (frame_done_i) begin
      if (frame_code_i == cand_q) begin
        if (stable_q != STABLE_MAX) stable_d = stable_q + 4'd1;
      end else begin
        cand_d   = frame_code_i;
        stable_d = 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cand_q   <= KEY_NONE;
      stable_q <= 4'd0;
      done_q   <= 1'b0;
    end else begin
      cand_q   <= cand_d;
      stable_q <= stable_d;
      done_q   <= frame_done_i;
    end
  end

  assign commit_o = done_q && (stable_q == STABLE_MAX);
  assign code_o   = cand_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x3 matrix scanner with frame debouncing and a one-hot digit output.
// Define KEYPAD_STAR_HASH_EN to add start_key/stop_key levels for STAR/HASH.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 100,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_COLS-1:0] cols_n,
  output logic [NUM_ROWS-1:0] rows_n,
  output logic [9:0]          keys,
`ifdef KEYPAD_STAR_HASH_EN
  output logic                key_strobe,
  output logic                start_key,
  output logic                stop_key
`else
  output logic                key_strobe
`endif
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  scan_state_e        state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         row_q, row_d;
  code_t              acc_q, acc_d, merged;
  logic [NUM_COLS-1:0] active;
  logic [1:0]         n_active, col_idx;
  logic               frame_done;
  code_t              frame_code;
  logic               commit;
  code_t              commit_code;
  logic [9:0]         keys_dec;
  logic [9:0]         keys_q, keys_d;
  logic               strobe_q, strobe_d;

  assign active   = ~cols_n;
  assign n_active = {1'b0, active[0]} + {1'b0, active[1]} + {1'b0, active[2]};
  assign col_idx  = active[0] ? 2'd0 : (active[1] ? 2'd1 : 2'd2);

  // Fold this row's sample into the running frame code.
  always_comb begin
    merged = acc_q;
    if (n_active > 2'd1) begin
      merged = KEY_MULTI;
    end else if (n_active == 2'd1) begin
      merged = (acc_q == KEY_NONE) ? key_code(row_q, col_idx) : KEY_MULTI;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    row_d      = row_q;
    acc_d      = acc_q;
    frame_done = 1'b0;
    frame_code = KEY_NONE;
    case (state_q)
      ST_DRIVE: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(SCAN_DIV - 2)) state_d = ST_SAMPLE;
      end
      default: begin
        cnt_d   = '0;
        row_d   = row_q + 2'd1;
        state_d = ST_DRIVE;
        if (row_q == 2'(NUM_ROWS - 1)) begin
          frame_done = 1'b1;
          frame_code = merged;
          acc_d      = KEY_NONE;
        end else begin
          acc_d = merged;
        end
      end
    endcase
  end

  keypad_debounce #(
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
  ) u_debounce (
    .clk         (clk),
    .reset       (reset),
    .frame_done_i(frame_done),
    .frame_code_i(frame_code),
    .commit_o    (commit),
    .code_o      (commit_code)
  );

  for (genvar gi = 0; gi < NUM_ROWS; gi++) begin : g_rows
    assign rows_n[gi] = (row_q != 2'(gi));
  end

  for (genvar gi = 0; gi < 10; gi++) begin : g_dec
    assign keys_dec[gi] = (commit_code == 4'(gi));
  end

  // STAR, HASH and MULTI leave keys alone; only a fresh non-zero digit strobes.
  always_comb begin
    keys_d   = keys_q;
    strobe_d = 1'b0;
    if (commit) begin
      if (commit_code == KEY_NONE) begin
        keys_d = '0;
      end else if (commit_code <= 4'd9) begin
        keys_d   = keys_dec;
        strobe_d = (keys_dec != keys_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_DRIVE;
      cnt_q    <= '0;
      row_q    <= 2'd0;
      acc_q    <= KEY_NONE;
      keys_q   <= '0;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      row_q    <= row_d;
      acc_q    <= acc_d;
      keys_q   <= keys_d;
      strobe_q <= strobe_d;
    end
  end

  assign keys       = keys_q;
  assign key_strobe = strobe_q;

`ifdef KEYPAD_STAR_HASH_EN
  logic start_q, stop_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      start_q <= 1'b0;
      stop_q  <= 1'b0;
    end else if (commit && commit_code != KEY_MULTI) begin
      start_q <= (commit_code == KEY_STAR);
      stop_q  <= (commit_code == KEY_HASH);
    end
  end

  assign start_key = start_q;
  assign stop_key  = stop_q;
`endif

endmodule
